// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  // Low bit of lane idx inside a packed multi-lane bus of lane width w.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback side bus of the register file: read lanes, write lanes, scrub control.
interface regfile_if import regfile_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned N_RD   = 2,
  parameter int unsigned N_WR   = 2
) ();

  logic                     clear_req;
  logic                     busy;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic [N_WR-1:0]          wr_en;
  logic [N_WR*ADDR_W-1:0]   wr_addr;
  logic [N_WR*DATA_W-1:0]   wr_data;
  logic                     wr_collide;

  modport master (
    output clear_req, rd_addr, wr_en, wr_addr, wr_data,
    input  busy, rd_data, wr_collide
  );

  modport slave (
    input  clear_req, rd_addr, wr_en, wr_addr, wr_data,
    output busy, rd_data, wr_collide
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Scrub sequencer: walks every entry once, writing zero, after reset or an accepted clear request.
module regfile_clear_seq import regfile_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
  end

  // Reset edge only arms the scrub; the first entry is cleared on the following edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    if (rst) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
          end
        end
        ST_CLEAR: begin
          clr_we = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with sequential scrub, highest-port-wins writes and collision flag.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read lanes.
module regfile_mp import regfile_pkg::*; #(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned N_WR     = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic                   busy;
  logic                   clr_we;
  logic [ADDR_W-1:0]      clr_addr;
  logic [N_WR-1:0]        wr_we_c;
  logic [ADDR_W-1:0]      wr_addr_c [N_WR];
  logic [DATA_W-1:0]      wr_data_c [N_WR];
  logic [N_RD*DATA_W-1:0] rd_data_c;
  logic                   wr_collide_c;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clear_req(bus.clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Unpack write lanes and qualify enables: nothing commits while scrubbing, on a reset edge, or to r0.
  always_comb begin
    wr_we_c = '0;
    for (int unsigned w = 0; w < N_WR; w++) begin
      wr_addr_c[w] = bus.wr_addr[slice_lo(w, ADDR_W) +: ADDR_W];
      wr_data_c[w] = bus.wr_data[slice_lo(w, DATA_W) +: DATA_W];
      wr_we_c[w]   = bus.wr_en[w] && !busy && !rst &&
                     !((ZERO_REG != 0) && (wr_addr_c[w] == '0));
    end
  end

  // Later ports are applied last so the highest-index port wins on an address clash.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    for (int unsigned w = 0; w < N_WR; w++) begin
      if (wr_we_c[w]) mem_q[wr_addr_c[w]] <= wr_data_c[w];
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    rd_data_c = '0;
    for (int unsigned p = 0; p < N_RD; p++) begin
      ra = bus.rd_addr[slice_lo(p, ADDR_W) +: ADDR_W];
      rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned w = 0; w < N_WR; w++) begin
        if (wr_we_c[w] && (wr_addr_c[w] == ra)) rv = wr_data_c[w];
      end
`endif
      if (busy || ((ZERO_REG != 0) && (ra == '0))) rv = '0;
      rd_data_c[slice_lo(p, DATA_W) +: DATA_W] = rv;
    end
  end

  always_comb begin
    wr_collide_c = 1'b0;
    for (int unsigned i = 0; i < N_WR; i++) begin
      for (int unsigned j = i + 1; j < N_WR; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] && (wr_addr_c[i] == wr_addr_c[j])) wr_collide_c = 1'b1;
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.rd_data    = rd_data_c;
  assign bus.wr_collide = wr_collide_c;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath: configurable data width, depth, read-port count and write-port count. Register 0 can be hardwired to zero. Contents are cleared by a sequential scrub engine, one entry per cycle, with a `busy` indication. This lets the storage map onto RAM-style arrays instead of a flop-per-bit parallel reset. The block sits between decode (read ports) and writeback (write ports), with optional same-cycle write-to-read forwarding.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- N_RD, 2, number of read ports (≥1).
- N_WR, 2, number of write ports (≥1).
- ZERO_REG, 1, when 1 entry 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high; starts a full scrub.
- clear_req  in  1  request a full scrub; sampled only in IDLE.
- busy  out  1  high while scrubbing.
- rd_addr  in  N_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rd_data  out  N_RD*DATA_W  read data; combinational from rd_addr.
- wr_en  in  N_WR  per-port write enable.
- wr_addr  in  N_WR*ADDR_W  write addresses, packed as for rd_addr.
- wr_data  in  N_WR*DATA_W  write data, packed likewise.
- wr_collide  out  1  combinational; high when two or more enabled write ports target the same address.

## Operation
FSM states:
- IDLE: normal access.
- CLEAR: scrub in progress.

Transitions and behaviour:
- Any edge with rst=1: state←CLEAR, ptr←0. No array write on that edge.
- CLEAR, rst=0: each edge writes entry[ptr]←0 and increments ptr. When ptr==DEPTH-1, state←IDLE; ptr wraps to 0.
- IDLE, clear_req=1, rst=0: state←CLEAR, ptr←0. In that same edge, enabled writes still commit.
- clear_req in CLEAR is ignored; it is not queued.
- rst during CLEAR restarts the scrub from ptr=0.

Output rules:
- busy = (state==CLEAR). Reset value of busy is 1. Reset value of rd_data is 0.
- While busy: all writes are dropped and every rd_data lane reads 0.
- Writes in IDLE: each port with wr_en=1 writes on the rising edge.
- ZERO_REG=1: writes to address 0 are discarded, and rd_addr==0 returns 0.
- Same-address collision: the highest-index enabled port wins. wr_collide is informational only.
- Reads are asynchronous. Without bypass, a read returns the pre-edge content.

## Timing
- Write latency: data is visible on rd_data the cycle after the write edge (without bypass).
- Scrub length: exactly DEPTH edges in CLEAR after rst falls or clear_req is accepted. busy drops after the edge that clears entry DEPTH-1.
- Reset-to-usable: rst deasserted before edge t → writes are accepted first at edge t+DEPTH.
- wr_collide and rd_data are purely combinational; no extra pipeline stage.

## Configuration
- REGFILE_BYPASS_EN defined: in IDLE, if an enabled write port targets a lane's rd_addr, rd_data returns that port's wr_data in the same cycle. Priority goes to the highest-index port. Address 0 is never forwarded when ZERO_REG=1. No forwarding while busy.
- REGFILE_BYPASS_EN undefined: no forwarding; reads always return stored content.

## Structure
- Package regfile_pkg holds:
  - state enum {ST_IDLE, ST_CLEAR};
  - default DATA_W/ADDR_W constants;
  - a localparam function for the packed-bus slice offset.
- Sub-module regfile_clear_seq: FSM plus ptr counter. Inputs rst and clear_req; outputs busy, clr_we, clr_addr.
- Top level holds the array, the write-priority mux, the read/bypass muxes and the collision detect.

## Test plan
- Reset scrub: rst high 1 cycle, then low → busy=1 for exactly 32 cycles (ADDR_W=5). Every rd_data=0 during scrub. All 32 entries read 0 afterwards.
- Basic write/read: port0 writes 0xDEADBEEF to r7 → next cycle rd_addr[0]=7 returns 0xDEADBEEF. A write to r0 leaves r0 reading 0.
- Collision: port0 writes 0x11 to r5 and port1 writes 0x22 to r5 in the same cycle → wr_collide=1 that cycle, and r5 reads 0x22 afterwards.
- Writes during scrub: clear_req at cycle t, port0 writes r3 at t+4 → write dropped, r3 reads 0 after busy falls. A write accepted at edge t itself is overwritten when ptr reaches 3.
- Reset mid-scrub: rst asserted at scrub cycle 10 → ptr restarts, and busy stays high a further 32 cycles after rst falls.
- Bypass (REGFILE_BYPASS_EN): write 0xCAFE to r9 while rd_addr[1]=9 → rd_data[1]=0xCAFE in the same cycle. Without the macro, the old value is returned that cycle.
